// File: rtl/npu_adder_pkg.sv
// Shared constants, FSM state encoding and result-width helper for the
// sequential popcount controller.
package npu_adder_pkg;

  localparam int unsigned SLICE_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned sum_width(input int unsigned nslice);
    return $clog2(SLICE_W * nslice + 1);
  endfunction

endpackage

// File: rtl/adder15_4.sv
// Combinational 15-input population count producing a 4-bit result.
module adder15_4 (
  input  logic [14:0] bits,
  output logic [3:0]  count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      count = count + 4'(bits[i]);
    end
  end

endmodule

// File: rtl/popcnt_seq_ctrl.sv
// Sequential popcount: captures a job, feeds one 15-bit slice per cycle into
// a shared adder15_4 and accumulates, then holds the result until taken.
module popcnt_seq_ctrl
  import npu_adder_pkg::*;
#(
  parameter  int unsigned NSLICE = 4,
  localparam int unsigned SUM_W  = sum_width(NSLICE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*NSLICE-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SUM_W-1:0]          out_sum,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t                    state_q, state_nxt;
  logic [SLICE_W*NSLICE-1:0] job_q;
  logic [SUM_W-1:0]          acc_q;
  logic [IDX_W-1:0]          idx_q;
  logic [SLICE_W-1:0]        slice;
  logic [3:0]                slice_cnt;
  logic                      accept;
  logic                      last;

  assign accept = in_valid && in_ready;
  assign last   = (idx_q == IDX_W'(NSLICE - 1));
  assign slice  = SLICE_W'(job_q >> (SLICE_W * idx_q));

  adder15_4 u_adder (
    .bits  (slice),
    .count (slice_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is masked by reset so a held reset never advertises acceptance.
  always_comb begin
    in_ready  = (state_q == IDLE) && !reset;
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      job_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            job_q <= in_data;
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_q + SUM_W'(slice_cnt);
          idx_q <= last ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_sum = acc_q;

endmodule

// File: tb/tb_popcnt_seq_ctrl.sv
// Directed and random checks of popcnt_seq_ctrl with NSLICE=4.
module tb_popcnt_seq_ctrl;

  localparam int unsigned NSLICE = 4;
  localparam int unsigned DW     = 15 * NSLICE;
  localparam int unsigned SW     = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  popcnt_seq_ctrl #(.NSLICE(NSLICE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Accept one job, check latency and result, optionally stall in DONE while
  // pulsing in_valid, then release with out_ready.
  task automatic do_job(input logic [DW-1:0] d, input logic [SW-1:0] exp,
                        input string nm, input int hold);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check({nm, " ready_before_accept"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({nm, " latency"}, lat, NSLICE);
    check({nm, " sum"}, out_sum, exp);
    check({nm, " busy_in_done"}, busy, 1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = rand_data();
      @(posedge clk); #1;
      check({nm, " hold_valid"}, out_valid, 1);
      check({nm, " hold_sum"}, out_sum, exp);
      check({nm, " hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, " valid_after_take"}, out_valid, 0);
    check({nm, " ready_after_take"}, in_ready, 1);
  endtask

  initial begin
    logic [DW-1:0] d;
    bit            seen;

    vecs[0] = '{data: '0,                    exp: 6'd0,  name: "zeros"};
    vecs[1] = '{data: '1,                    exp: 6'd60, name: "ones"};
    vecs[2] = '{data: 60'h000_0000_0000_7FFF, exp: 6'd15, name: "low_slice"};
    vecs[3] = '{data: 60'h555_5555_5555_5555, exp: 6'd30, name: "alternating"};
    vecs[4] = '{data: 60'hFFF_E000_0000_0000, exp: 6'd15, name: "top_slice"};
    vecs[5] = '{data: 60'h800_0000_0000_0001, exp: 6'd2,  name: "end_bits"};
    vecs[6] = '{data: 60'h123_4567_89AB_CDEF, exp: 6'd32, name: "hex_ramp"};

    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = '1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_out_sum", out_sum, 0);

    for (int i = 0; i < 7; i++) begin
      do_job(vecs[i].data, vecs[i].exp, vecs[i].name, 0);
    end

    // Stall in DONE with in_valid pulses; the following job must be clean.
    do_job(60'h000_0000_0000_0FFF, 6'd12, "hold", 3);
    do_job(60'h000_0000_0000_000F, 6'd4, "after_hold", 0);

    // Abort a job with reset during its second RUN cycle.
    in_valid = 1'b1;
    in_data  = '1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_sum", out_sum, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    do_job('1, 6'd60, "after_abort", 0);

    for (int j = 0; j < 1000; j++) begin
      d = rand_data();
      do_job(d, SW'($countones(d)), "random", int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/popcnt_seq_ctrl.md
POPCNT_SEQ_CTRL -- requirements
Module: popcnt_seq_ctrl

Interface
REQ-001 SHALL have parameter NSLICE, default 4, number of 15-bit slices per job (1..16).
REQ-002 SHALL have derived constant SUM_W = clog2(15*NSLICE+1), default 6, result width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  job request.
REQ-006 SHALL have port in_ready  output  1  controller can accept a job.
REQ-007 SHALL have port in_data  input  15*NSLICE  bit vector to count.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port out_sum  output  SUM_W  number of set bits in the accepted in_data.
REQ-011 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-013 IDLE: on in_valid&in_ready SHALL capture in_data into a job register, clear acc and slice index idx, and go to RUN.
REQ-014 in_data changes after the accepting edge SHALL have no effect on the job in flight.
REQ-015 RUN: each cycle SHALL present job bits [15*idx+14 : 15*idx] to one shared adder15_4 and add its 4-bit result, zero-extended, to acc (SUM_W bits).
REQ-016 RUN: idx SHALL increment each cycle; on the cycle with idx==NSLICE-1 the FSM SHALL go to DONE after the final add.
REQ-017 Latency: with the accept on edge T, out_valid SHALL be high after edge T+NSLICE, i.e. NSLICE cycles in RUN.
REQ-018 DONE: out_sum SHALL equal acc and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 DONE with out_ready=1 SHALL return to IDLE on that edge, so the next accept is possible one cycle later; no job overlap.
REQ-020 in_valid while busy SHALL be ignored and SHALL NOT be captured.
REQ-021 acc SHALL NOT overflow: the maximum 15*NSLICE fits SUM_W by construction.
REQ-022 NSLICE=1 SHALL give exactly one RUN cycle.
REQ-023 Slice-bit-to-adder-input mapping is free: the sum is order-independent.

Reset
REQ-024 reset SHALL force state=IDLE, idx=0, acc=0, out_sum=0, out_valid=0, busy=0 and in_ready=1 from the next cycle on.
REQ-025 reset SHALL take priority over every handshake, including mid-RUN and in DONE; an aborted job SHALL produce no output.
REQ-026 reset held high SHALL keep in_ready=0 during reset cycles and SHALL accept no job.

Structure
REQ-027 Package npu_adder_pkg SHALL hold SLICE_W=15, the FSM state enum and the SUM_W width function.
REQ-028 SHALL instantiate exactly one existing adder15_4 (15-input, 4-bit count) as its only sub-module.
REQ-029 The job register, acc, idx and FSM SHALL be the only sequential state; out_sum SHALL be driven from the acc register.

Verification (NSLICE=4)
REQ-030 Reset, then accept in_data=0 -> out_valid rises 4 cycles after accept with out_sum=0.
REQ-031 Accept in_data = all ones (60 bits) -> out_sum=60; accept in_data=0x7FFF -> out_sum=15.
REQ-032 Accept in_data = 0x5555_5555_5555_555 (alternating bits) -> out_sum=30.
REQ-033 Hold out_ready=0 for 3 cycles in DONE and pulse in_valid -> out_sum held, in_ready=0, pulse ignored; later job unaffected.
REQ-034 Assert reset in the 2nd RUN cycle -> next cycle IDLE, out_valid=0, in_ready=1; no result for the aborted job; next job (all ones) gives 60.
REQ-035 Run 1000 random back-to-back jobs with random out_ready -> every out_sum equals the software popcount; error counter=0.
